des_perm_pipe: RTL and testbench

//  Parametrised, pipelined DES permutation unit for the datapath front and back ends.

---
 rtl/des_pkg.sv | 47 ++++
 rtl/des_perm_stage.sv | 47 ++++
 rtl/des_perm_pipe.sv | 86 ++++++++
 tb/tb_des_perm_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES IP/FP permutation tables and the shared permute helper.
// Bit numbering is DES style: bit 1 is the MSB of a 64-bit word.
package des_pkg;

  typedef enum logic {
    PERM_IP = 1'b0,
    PERM_FP = 1'b1
  } perm_mode_e;

  typedef logic [6:0] perm_tbl_t [1:64];

  localparam perm_tbl_t IP_TABLE = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam perm_tbl_t FP_TABLE = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // DES bit n lives at vector index 64-n.
  function automatic logic [63:0] des_permute(
    input logic [63:0] data,
    input perm_tbl_t   tbl
  );
    logic [63:0] res;
    res = '0;
    for (int i = 1; i <= 64; i++) begin
      res[6'(64 - i)] = data[6'(7'd64 - tbl[i])];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_perm_stage.sv
// One pipeline slot {valid, mode, tag, data} with
// elastic ready: accepts when empty or draining.
module des_perm_stage
  import des_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic [TAG_W-1:0] up_tag,
  input  logic [63:0]      up_data,
  output logic             up_ready,
  input  logic             dn_ready,
  output logic             valid,
  output logic             mode,
  output logic [TAG_W-1:0] tag,
  output logic [63:0]      data
);

  always_comb begin
    up_ready = ~flush & (~valid | dn_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (up_ready) begin
        valid <= up_valid;
      end
      if (up_ready && up_valid) begin
        mode <= up_mode;
        tag  <= up_tag;
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP permutation with valid/ready,
// sideband tag and synchronous flush.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic [63:0]      out_data,
  output logic             busy
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("des_perm_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag_w
    $error("des_perm_pipe: TAG_W must be 1..16");
  end

  logic             v [0:STAGES];
  logic             r [0:STAGES];
  logic             m [0:STAGES];
  logic [TAG_W-1:0] t [0:STAGES];
  logic [63:0]      d [0:STAGES];
  logic [63:0]      perm_data;

  always_comb begin
    if (in_mode == PERM_FP) begin
      perm_data = des_permute(in_data, FP_TABLE);
    end else begin
      perm_data = des_permute(in_data, IP_TABLE);
    end
  end

  assign v[0]      = in_valid;
  assign m[0]      = in_mode;
  assign t[0]      = in_tag;
  assign d[0]      = perm_data;
  assign r[STAGES] = out_ready;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    des_perm_stage #(
      .TAG_W(TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .up_valid(v[k-1]),
      .up_mode (m[k-1]),
      .up_tag  (t[k-1]),
      .up_data (d[k-1]),
      .up_ready(r[k-1]),
      .dn_ready(r[k]),
      .valid   (v[k]),
      .mode    (m[k]),
      .tag     (t[k]),
      .data    (d[k])
    );
  end

  assign in_ready  = r[0];
  assign out_valid = v[STAGES];
  assign out_mode  = m[STAGES];
  assign out_tag   = t[STAGES];
  assign out_data  = d[STAGES];

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      busy = busy | v[k];
    end
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Randomized bench for des_perm_pipe against a
// table-free DES permutation model and a scoreboard.
module tb_des_perm_pipe;

  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic             m;
    logic [TAG_W-1:0] t;
    logic [63:0]      d;
  } blk_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;
  logic [63:0]      out_data;
  logic             busy;

  int   errors = 0;
  int   checks = 0;
  int   ip_t [64];
  int   fp_t [64];
  blk_t exp_q [$];

  always #5 clk = ~clk;

  des_perm_pipe #(
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .out_tag  (out_tag),
    .out_data (out_data),
    .busy     (busy)
  );

  // IP rows count down by 8: even sources 58..64 first, then odd 57..63.
  // FP is built as the inverse of IP.
  function automatic void build_tables();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ip_t[8*r+c] = ((r < 4) ? 58 + 2*r : 57 + 2*(r-4)) - 8*c;
    for (int i = 0; i < 64; i++) fp_t[ip_t[i]-1] = i + 1;
  endfunction

  function automatic logic [63:0] ref_perm(input logic md, input logic [63:0] x);
    logic [63:0] y;
    int src;
    y = '0;
    for (int i = 1; i <= 64; i++) begin
      src = md ? fp_t[i-1] : ip_t[i-1];
      y[64-i] = x[64-src];
    end
    return y;
  endfunction

  // Advance one clock: report handshakes seen before the edge and keep
  // the scoreboard of in-flight blocks up to date.
  task automatic step(output logic fi, output logic fo,
                      output blk_t got, output blk_t want);
    #1;
    fi   = in_valid && in_ready;
    fo   = out_valid && out_ready && !flush;
    got  = {out_mode, out_tag, out_data};
    want = 'x;
    if (fo && exp_q.size() > 0) want = exp_q.pop_front();
    @(posedge clk);
    if (flush) exp_q.delete();
    else if (fi) exp_q.push_back({in_mode, in_tag, ref_perm(in_mode, in_data)});
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_tag = '0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, out_mode, out_tag, out_data} !== '0)
      $display("FAIL reset_outputs: got v=%b b=%b m=%b t=%h d=%h want all 0",
               out_valid, busy, out_mode, out_tag, out_data);
    if ({out_valid, busy, out_mode, out_tag, out_data} !== '0) errors++;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got v=%b b=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic send_one(input logic md, input logic [63:0] dat,
                          input logic [TAG_W-1:0] tg,
                          input logic [63:0] golden, input string name);
    logic fi, fo;
    blk_t got, want;
    int lat;
    in_valid = 1'b1; in_mode = md; in_tag = tg; in_data = dat;
    out_ready = 1'b1;
    step(fi, fo, got, want);
    in_valid = 1'b0;
    checks++;
    if (fi !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: got %b want 1", name, fi);
    end
    lat = 0; fo = 1'b0;
    while (!fo && lat < 20) begin
      step(fi, fo, got, want);
      lat++;
    end
    checks++;
    if (!fo || lat != STAGES) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, STAGES);
    end
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s_model: got %h want %h", name, got, want);
    end
    checks++;
    if (got.d !== golden || got.m !== md || got.t !== tg) begin
      errors++;
      $display("FAIL %s_golden: got m=%b t=%h d=%h want m=%b t=%h d=%h",
               name, got.m, got.t, got.d, md, tg, golden);
    end
  endtask

  task automatic test_vectors();
    send_one(1'b0, 64'h0123456789ABCDEF, 4'h1, 64'hCC00CCFFF0AAF0AA, "ip_std");
    send_one(1'b1, 64'hCC00CCFFF0AAF0AA, 4'h2, 64'h0123456789ABCDEF, "fp_std");
    send_one(1'b0, 64'h0000000000000040, 4'h3, 64'h8000000000000000, "ip_bit58");
    send_one(1'b0, '1, 4'h4, '1, "ip_ones");
    send_one(1'b1, '0, 4'h5, '0, "fp_zeros");
  endtask

  task automatic test_backpressure();
    logic fi, fo, stall, cur_stall;
    blk_t got, want, prev;
    logic [63:0] dat [10];
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; stall = 1'b0; prev = '0;
    for (int i = 0; i < 10; i++) dat[i] = {$urandom, $urandom};
    while (rcvd < 10 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      in_mode   = sent[0];
      in_tag    = TAG_W'(sent);
      in_data   = dat[sent % 10];
      #1;
      checks++;
      if (in_ready !== !(exp_q.size() == STAGES && !out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready: got %b occupancy %0d out_ready %b",
                 in_ready, exp_q.size(), out_ready);
      end
      cur_stall = out_valid && !out_ready;
      step(fi, fo, got, want);
      if (stall) begin
        checks++;
        if (got !== prev) begin
          errors++;
          $display("FAIL bp_stable: got %h want %h", got, prev);
        end
      end
      prev = got; stall = cur_stall;
      if (fi) sent++;
      if (fo) begin
        checks++;
        if (got !== want || got.t !== TAG_W'(rcvd) || got.m !== rcvd[0]) begin
          errors++;
          $display("FAIL bp_order: got %h want %h tag %0d", got, want, rcvd);
        end
        rcvd++;
      end
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL bp_busy: got %b want %b", busy, exp_q.size() != 0);
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d want 10", rcvd);
    end
  endtask

  task automatic test_back_to_back();
    logic fi, fo;
    blk_t got, want;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    out_ready = 1'b1;
    while (rcvd < 20 && cyc < 100) begin
      in_valid = (sent < 20);
      in_mode  = 1'($urandom_range(0, 1));
      in_tag   = TAG_W'($urandom);
      in_data  = {$urandom, $urandom};
      #1;
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
      end
      step(fi, fo, got, want);
      if (fi) sent++;
      if (fo) begin
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_data: got %h want %h", got, want);
        end
        rcvd++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != 20 || cyc != 20 + STAGES) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d blocks in %0d cycles want 20 in %0d",
               rcvd, cyc, 20 + STAGES);
    end
  endtask

  task automatic test_flush();
    logic fi, fo;
    blk_t got, want;
    int seen;
    out_ready = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      in_valid = 1'b1; in_mode = 1'(k); in_tag = TAG_W'(12 + k);
      in_data = {$urandom, $urandom};
      step(fi, fo, got, want);
    end
    checks++;
    if (exp_q.size() != STAGES || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill: got occupancy %0d v=%b want %0d 1",
               exp_q.size(), out_valid, STAGES);
    end
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'hF; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    step(fi, fo, got, want);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got v=%b b=%b want 0 0", out_valid, busy);
    end
    in_valid = 1'b1; in_mode = 1'b0; in_tag = 4'hA; in_data = {$urandom, $urandom};
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume: got %b want 1", in_ready);
    end
    step(fi, fo, got, want);
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step(fi, fo, got, want);
      if (fo) begin
        seen++;
        checks++;
        if (got !== want || got.t !== 4'hA) begin
          errors++;
          $display("FAIL flush_leak: got %h want %h", got, want);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL flush_count: got %0d deliveries want 1", seen);
    end
  endtask

  task automatic test_async_reset();
    logic fi, fo;
    blk_t got, want;
    out_ready = 1'b1;
    for (int k = 0; k < STAGES + 2; k++) begin
      in_valid = 1'b1; in_mode = 1'(k); in_tag = TAG_W'(k + 5);
      in_data = {$urandom | 32'h1, $urandom};
      step(fi, fo, got, want);
    end
    #2;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got v=%b b=%b want 1 1", out_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, out_mode, out_tag, out_data} !== '0) begin
      errors++;
      $display("FAIL arst_outputs: got v=%b b=%b t=%h d=%h want all 0",
               out_valid, busy, out_tag, out_data);
    end
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_one(1'b0, 64'h0123456789ABCDEF, 4'h7, 64'hCC00CCFFF0AAF0AA, "arst_ip");
  endtask

  initial begin
    build_tables();
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
